// File: rtl/top.sv
// Register bank: DEPTH words of DATA_W bits, one write port and
// one registered read port sharing a single address bus.
module top #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        wr_sel = '0;
        if (write_en) begin
            wr_sel[addr] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = wr_sel[i] ? data_in : mem_q[i];
        end
    end

    // A read in the same cycle as a write returns the new data.
    always_comb begin
        rdata_d = rdata_q;
        if (read_en) begin
            rdata_d = write_en ? data_in : mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign data_out = rdata_q;

endmodule

// File: tb/tb_top.sv
// Bench for the register bank: array model checked every cycle
// plus hand-computed literal expectations.
module tb_top;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en  = 1'b0;
    logic [AW-1:0] addr     = '0;
    logic [DW-1:0] data_in  = '0;
    logic [DW-1:0] data_out;

    top #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_out;
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            chk_on   = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) check("cycle", data_out, model_out);
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_out = '0;
    endtask

    // One clock: drive strobes, let the edge happen, update the model.
    task automatic step(input logic we, input logic re,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] old;
        write_en = we;
        read_en  = re;
        addr     = a;
        data_in  = d;
        @(posedge clk);
        if (rst) begin
            old = model_mem[a];
            if (we) model_mem[a] = d;
            if (re) model_out = we ? d : old;
        end
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    // Mid-cycle asynchronous reset, with a strobe attempted while held.
    task automatic pulse_reset();
        #2 rst = 1'b0;
        model_clear();
        #1 check("rst_async", data_out, 16'h0000);
        step(1'b1, 1'b1, 4'd3, 16'h7777);
        #2 rst = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_init", data_out, 16'h0000);
        #2 rst = 1'b1;
        chk_on = 1'b1;

        step(1'b1, 1'b0, 4'd7, 16'hDEAD);
        step(1'b1, 1'b1, 4'd8, 16'hBEEF);
        check("pre_bypass", data_out, 16'hBEEF);

        pulse_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, AW'(i), 16'h0);
            check($sformatf("rd_zero[%0d]", i), data_out, 16'h0000);
        end

        step(1'b1, 1'b0, 4'd0, 16'h1234);
        step(1'b0, 1'b1, 4'd0, 16'h0);
        check("r0", data_out, 16'h1234);
        step(1'b1, 1'b0, 4'd1, 16'hABCD);
        step(1'b0, 1'b1, 4'd1, 16'h0);
        check("r1", data_out, 16'hABCD);
        step(1'b1, 1'b0, 4'd2, 16'h9876);
        step(1'b0, 1'b1, 4'd2, 16'h0);
        check("r2", data_out, 16'h9876);
        step(1'b0, 1'b1, 4'd0, 16'h0);
        check("r0_again", data_out, 16'h1234);

        step(1'b0, 1'b1, 4'd1, 16'h0);
        check("r1_again", data_out, 16'hABCD);
        repeat (3) step(1'b0, 1'b0, 4'd2, 16'hFFFF);
        check("hold", data_out, 16'hABCD);

        step(1'b1, 1'b1, 4'd5, 16'h5A5A);
        check("same_cycle", data_out, 16'h5A5A);
        step(1'b0, 1'b1, 4'd5, 16'h0);
        check("r5", data_out, 16'h5A5A);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, AW'(i), DW'(16'h1000 + i));
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, AW'(i), 16'h0);
            check($sformatf("sweep[%0d]", i), data_out,
                  DW'(16'h1000 + i));
        end

        step(1'b0, 1'b0, 4'd3, 16'hFFFF);
        step(1'b0, 1'b1, 4'd3, 16'h0);
        check("idle_no_effect", data_out, 16'h1003);

        pulse_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, AW'(i), 16'h0);
            check($sformatf("post_rst[%0d]", i), data_out, 16'h0000);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
